// File: rtl/ps2_keymap_decoder.sv
// PS/2 Set-2 scan-code decoder: follows E0/F0/E1 prefixes, maps configured codes onto a
// held-key vector and emits one-cycle make/break/repeat events with a stale-prefix timeout.
module ps2_keymap_decoder #(
   parameter int NUM_KEYS = 8,
   parameter logic [9*NUM_KEYS-1:0] KEY_CODES = {9'h004, 9'h006, 9'h005, 9'h02D,
                                                 9'h023, 9'h01B, 9'h01C, 9'h01D},
   parameter int TIMEOUT_CYCLES = 200000,
   localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                rx_done,
   input  logic [7:0]          rx_data,
   output logic [NUM_KEYS-1:0] key_state,
   output logic                event_valid,
   output logic                event_release,
   output logic                event_repeat,
   output logic                event_mapped,
   output logic [IDX_W-1:0]    event_index,
   output logic [8:0]          event_code
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_t;
   typedef enum logic [2:0] {K_E0, K_F0, K_E1, K_BAT, K_ERR, K_ACK, K_FAKE, K_OTHER} kind_t;

   state_t              state;
   logic   [2:0]        skip_cnt;
   logic   [CNT_W-1:0]  tmo_cnt;

   kind_t               kind;
   logic                restart;
   logic                fire;
   logic                rel;
   logic                clear_all;
   logic   [8:0]        cand_code;
   logic                hit;
   logic   [IDX_W-1:0]  hit_idx;
   logic   [NUM_KEYS-1:0] onehot;

   function automatic state_t prefix_state(input kind_t k);
      case (k)
         K_E0:    return S_EXT;
         K_F0:    return S_BRK;
         K_E1:    return S_PAUSE;
         default: return S_IDLE;
      endcase
   endfunction

   always_comb begin
      case (rx_data)
         8'hE0:               kind = K_E0;
         8'hF0:               kind = K_F0;
         8'hE1:               kind = K_E1;
         8'hAA:               kind = K_BAT;
         8'h00, 8'hFF:        kind = K_ERR;
         8'hFA, 8'hEE, 8'hFE: kind = K_ACK;
         8'h12, 8'h59:        kind = K_FAKE;
         default:             kind = K_OTHER;
      endcase
   end

   // A byte that "restarts" is handled exactly as if the FSM were idle.
   always_comb begin
      restart = 1'b0;
      case (state)
         S_IDLE:            restart = 1'b1;
         S_EXT:             restart = kind inside {K_E0, K_E1, K_BAT, K_ERR};
         S_BRK, S_EXT_BRK:  restart = kind inside {K_E0, K_E1, K_F0, K_ERR};
         default:           restart = 1'b0;
      endcase
   end

   always_comb begin
      fire = 1'b0;
      if (rx_done) begin
         case (state)
            S_IDLE:    fire = kind inside {K_FAKE, K_OTHER};
            S_EXT:     fire = !restart && (kind inside {K_ACK, K_OTHER});
            S_BRK:     fire = !restart;
            S_EXT_BRK: fire = !restart && (kind != K_FAKE);
            default:   fire = 1'b0;
         endcase
      end
      rel       = (state == S_BRK) || (state == S_EXT_BRK);
      clear_all = rx_done && restart && (kind inside {K_BAT, K_ERR});
      cand_code = {(state == S_EXT) || (state == S_EXT_BRK), rx_data};
   end

   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      // NOTE: scanning downward makes the lowest matching entry the last write, so it wins.
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (KEY_CODES[9*i +: 9] == cand_code) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
      onehot = hit ? (NUM_KEYS'(1) << hit_idx) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         skip_cnt      <= '0;
         tmo_cnt       <= '0;
         key_state     <= '0;
         event_valid   <= 1'b0;
         event_release <= 1'b0;
         event_repeat  <= 1'b0;
         event_mapped  <= 1'b0;
         event_index   <= '0;
         event_code    <= '0;
      end else begin
         event_valid <= fire;
         if (fire) begin
            event_release <= rel;
            event_repeat  <= !rel && |(key_state & onehot);
            event_mapped  <= hit;
            event_index   <= hit_idx;
            event_code    <= cand_code;
         end

         if (clear_all)
            key_state <= '0;
         else if (fire)
            key_state <= rel ? (key_state & ~onehot) : (key_state | onehot);

         if (rx_done) begin
            tmo_cnt <= '0;
            if (restart) begin
               state <= prefix_state(kind);
               if (kind == K_E1)
                  skip_cnt <= 3'd7;
            end else begin
               case (state)
                  S_EXT:   state <= (kind == K_F0) ? S_EXT_BRK : S_IDLE;
                  S_PAUSE: begin
                     if (skip_cnt <= 3'd1) begin
                        skip_cnt <= '0;
                        state    <= S_IDLE;
                     end else begin
                        skip_cnt <= skip_cnt - 3'd1;
                     end
                  end
                  default: state <= S_IDLE;
               endcase
            end
         end else if (tmo_cnt != CNT_MAX) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
         end else if (state != S_IDLE) begin
            // Stale prefix: the rest of the code was lost, drop back without an event.
            state <= S_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_ps2_keymap_decoder.sv
// Scoreboard bench for ps2_keymap_decoder: expected events are queued as bytes are sent
// and compared when the decoder pulses event_valid.
module tb_ps2_keymap_decoder;

   localparam int NK = 10;
   localparam int IW = 4;
   localparam int TO = 40;
   localparam logic [9*NK-1:0] CODES = {9'h01D, 9'h175, 9'h004, 9'h006, 9'h005,
                                        9'h02D, 9'h023, 9'h01B, 9'h01C, 9'h01D};

   logic          clk;
   logic          reset;
   logic          rx_done;
   logic [7:0]    rx_data;
   logic [NK-1:0] key_state;
   logic          event_valid;
   logic          event_release;
   logic          event_repeat;
   logic          event_mapped;
   logic [IW-1:0] event_index;
   logic [8:0]    event_code;

   ps2_keymap_decoder #(
      .NUM_KEYS(NK),
      .KEY_CODES(CODES),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rx_done(rx_done),
      .rx_data(rx_data),
      .key_state(key_state),
      .event_valid(event_valid),
      .event_release(event_release),
      .event_repeat(event_repeat),
      .event_mapped(event_mapped),
      .event_index(event_index),
      .event_code(event_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          rel;
      logic          rep;
      logic          map;
      logic [IW-1:0] idx;
      logic [8:0]    code;
      logic [NK-1:0] ks;
   } ev_t;

   ev_t q[$];
   int  total = 0;
   int  bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic exp_ev(input logic rel, input logic rep, input logic map,
                         input logic [IW-1:0] idx, input logic [8:0] code,
                         input logic [NK-1:0] ks);
      ev_t e;
      e.rel  = rel;
      e.rep  = rep;
      e.map  = map;
      e.idx  = idx;
      e.code = code;
      e.ks   = ks;
      q.push_back(e);
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_done = 1'b1;
      rx_data = b;
   endtask

   // Exactly n idle clock edges elapse before the next send() strobe is sampled.
   task automatic idle(input int n);
      @(negedge clk);
      rx_done = 1'b0;
      rx_data = 8'($urandom);
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic drain(input string tag);
      idle(4);
      check(tag, 32'(q.size()), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_key_state"}, 32'(key_state), 32'd0);
      check({tag, "_valid"},     32'(event_valid), 32'd0);
      check({tag, "_release"},   32'(event_release), 32'd0);
      check({tag, "_repeat"},    32'(event_repeat), 32'd0);
      check({tag, "_mapped"},    32'(event_mapped), 32'd0);
      check({tag, "_index"},     32'(event_index), 32'd0);
      check({tag, "_code"},      32'(event_code), 32'd0);
   endtask

   always @(negedge clk) begin : monitor
      ev_t e;
      if (event_valid) begin
         if (q.size() == 0) begin
            check("unexpected_event", 32'(event_valid), 32'd0);
         end else begin
            e = q.pop_front();
            check("ev_release", 32'(event_release), 32'(e.rel));
            check("ev_repeat",  32'(event_repeat),  32'(e.rep));
            check("ev_mapped",  32'(event_mapped),  32'(e.map));
            check("ev_index",   32'(event_index),   32'(e.idx));
            check("ev_code",    32'(event_code),    32'(e.code));
            check("ev_keys",    32'(key_state),     32'(e.ks));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got=running expected=done");
      $fatal(1);
   end

   initial begin
      reset   = 1'b1;
      rx_done = 1'b0;
      rx_data = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_all_zero("reset");

      // W press/release; duplicate entry 9 must lose to entry 0.
      exp_ev(0, 0, 1, 0, 9'h01D, 10'h001);
      send(8'h1D);
      exp_ev(1, 0, 1, 0, 9'h01D, 10'h000);
      send(8'hF0); send(8'h1D);
      drain("drain_w");

      // Extended up arrow.
      exp_ev(0, 0, 1, 8, 9'h175, 10'h100);
      send(8'hE0); send(8'h75);
      exp_ev(1, 0, 1, 8, 9'h175, 10'h000);
      send(8'hE0); send(8'hF0); send(8'h75);
      drain("drain_ext");

      // Typematic repeat, unmapped key, release.
      exp_ev(0, 0, 1, 1, 9'h01C, 10'h002);
      exp_ev(0, 1, 1, 1, 9'h01C, 10'h002);
      send(8'h1C); send(8'h1C);
      exp_ev(0, 0, 0, 0, 9'h015, 10'h002);
      send(8'h15);
      exp_ev(1, 0, 1, 1, 9'h01C, 10'h000);
      send(8'hF0); send(8'h1C);
      drain("drain_typematic");

      // Pause sequence and fake shifts produce nothing.
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      send(8'hE0); send(8'h12);
      exp_ev(0, 0, 1, 3, 9'h023, 10'h008);
      send(8'h23);
      send(8'hE0); send(8'hF0); send(8'h12);
      exp_ev(1, 0, 1, 3, 9'h023, 10'h000);
      send(8'hF0); send(8'h23);
      drain("drain_pause");

      // Break of a key that is not held still reports.
      exp_ev(1, 0, 1, 2, 9'h01B, 10'h000);
      send(8'hF0); send(8'h1B);
      drain("drain_unheld_break");

      // Timeout boundary: exactly TO idle edges keeps the prefix, TO+1 drops it.
      send(8'hF0);
      idle(TO);
      exp_ev(1, 0, 1, 0, 9'h01D, 10'h000);
      send(8'h1D);
      send(8'hF0);
      idle(TO + 1);
      exp_ev(0, 0, 1, 0, 9'h01D, 10'h001);
      send(8'h1D);
      send(8'hE0);
      idle(TO + 1);
      exp_ev(0, 0, 0, 0, 9'h075, 10'h001);
      send(8'h75);
      drain("drain_timeout");

      // BAT clears all held keys without an event; event fields hold.
      exp_ev(0, 0, 1, 2, 9'h01B, 10'h005);
      send(8'h1B);
      exp_ev(0, 0, 1, 7, 9'h004, 10'h085);
      send(8'h04);
      send(8'hAA);
      drain("drain_bat");
      check("bat_key_state", 32'(key_state), 32'd0);
      check("bat_code_hold", 32'(event_code), 32'h004);

      // Reset wins over a concurrent strobe.
      exp_ev(0, 0, 1, 0, 9'h01D, 10'h001);
      send(8'h1D);
      drain("drain_pre_reset");
      @(negedge clk);
      reset   = 1'b1;
      rx_done = 1'b1;
      rx_data = 8'h1D;
      @(negedge clk);
      reset   = 1'b0;
      rx_done = 1'b0;
      check_all_zero("reset_rx");

      // Reset mid-prefix discards the pending F0.
      send(8'hF0);
      idle(1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_ev(0, 0, 1, 0, 9'h01D, 10'h001);
      send(8'h1D);
      drain("drain_reset_prefix");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
